// File: rtl/imm_ext_pkg.sv
// Shared mode and state encodings for the immediate extension/assembly unit.
// Imported by the combinational extender and the registered top level.
package imm_ext_pkg;

    localparam logic [1:0] MODE_ZERO   = 2'b00;
    localparam logic [1:0] MODE_SIGN   = 2'b01;
    localparam logic [1:0] MODE_SHIFT  = 2'b10;
    localparam logic [1:0] MODE_CONCAT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_COLLECT = 2'b01,
        S_HOLD    = 2'b10
    } state_e;

endpackage

// File: rtl/imm_ext_comb.sv
// Single-beat zero/sign/shift extension of an IN_W chunk to OUT_W bits.
// Purely combinational; CONCAT is assembled by the parent.
module imm_ext_comb
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  a_i,
    input  logic [1:0]       mode_i,
    output logic [OUT_W-1:0] res_o
);

    logic [OUT_W-1:0] zext;

    assign zext = OUT_W'(a_i);

    always_comb begin
        res_o = '0;
        unique case (mode_i)
            MODE_ZERO:   res_o = zext;
            MODE_SIGN:   res_o = {{(OUT_W-IN_W){a_i[IN_W-1]}}, a_i};
            MODE_SHIFT:  res_o = zext << IN_W;
            MODE_CONCAT: res_o = '0;
            default:     res_o = '0;
        endcase
    end

endmodule

// File: rtl/imm_extend_assembler.sv
// Registered immediate extender with multi-beat CONCAT assembly and a
// single output buffer supporting same-cycle drain-and-refill.
module imm_extend_assembler
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int OUT_W = 16
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [IN_W-1:0]  A,
    input  logic [1:0]       Mode,
    input  logic             Last,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [OUT_W-1:0] R
);

    localparam int NCHUNK = OUT_W / IN_W;
    localparam int CW     = $clog2(NCHUNK + 1);
    localparam logic [CW-1:0] NCHUNK_C = CW'(NCHUNK);

    if (((OUT_W % IN_W) != 0) || (OUT_W <= IN_W)) begin : g_bad_width
        $error("imm_extend_assembler: OUT_W must be a multiple of IN_W and larger");
    end

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [OUT_W-1:0] r_q, r_d;

    logic             accept;
    logic             fire;
    logic [OUT_W-1:0] single_res;
    logic [OUT_W-1:0] a_ext;
    logic [OUT_W-1:0] acc_shift;
    logic [CW-1:0]    cnt_inc;

    imm_ext_comb #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_comb (
        .a_i    (A),
        .mode_i (Mode),
        .res_o  (single_res)
    );

    assign Out_Valid = (state_q == S_HOLD);
    assign In_Ready  = Reset_n & ((state_q != S_HOLD) | Out_Ready);
    assign R         = r_q;

    assign accept    = In_Valid & In_Ready;
    assign fire      = Out_Valid & Out_Ready;
    assign a_ext     = OUT_W'(A);
    assign acc_shift = (acc_q << IN_W) | a_ext;
    assign cnt_inc   = cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        r_d     = r_q;
        unique case (state_q)
            S_IDLE, S_HOLD: begin
                // In HOLD an accept implies a fire, so the buffer is free.
                if (accept) begin
                    if (Mode == MODE_CONCAT) begin
                        if (Last || (NCHUNK == 1)) begin
                            r_d     = a_ext;
                            acc_d   = '0;
                            cnt_d   = '0;
                            state_d = S_HOLD;
                        end else begin
                            acc_d   = a_ext;
                            cnt_d   = CW'(1);
                            state_d = S_COLLECT;
                        end
                    end else begin
                        r_d     = single_res;
                        state_d = S_HOLD;
                    end
                end else if (fire) begin
                    state_d = S_IDLE;
                end
            end
            S_COLLECT: begin
                if (accept) begin
                    if (Last || (cnt_inc == NCHUNK_C)) begin
                        r_d     = acc_shift;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = S_HOLD;
                    end else begin
                        acc_d = acc_shift;
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                acc_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            r_q     <= r_d;
        end
    end

endmodule

// File: tb/tb_imm_extend_assembler.sv
// Directed and randomized checks of imm_extend_assembler (IN_W=4, OUT_W=16)
// against a transaction-level reference model.
module tb_imm_extend_assembler;

    logic        CLK;
    logic        Reset_n;
    logic        In_Valid;
    logic        In_Ready;
    logic [3:0]  A;
    logic [1:0]  Mode;
    logic        Last;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [15:0] R;

    int total = 0;
    int bad   = 0;

    imm_extend_assembler #(
        .IN_W  (4),
        .OUT_W (16)
    ) dut (
        .CLK       (CLK),
        .Reset_n   (Reset_n),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .A         (A),
        .Mode      (Mode),
        .Last      (Last),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .R         (R)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic drive(input logic v, input logic [3:0] a,
                         input logic [1:0] m, input logic l,
                         input logic ordy);
        @(negedge CLK);
        In_Valid  = v;
        A         = a;
        Mode      = m;
        Last      = l;
        Out_Ready = ordy;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        In_Valid = 1'b0; A = '0; Mode = '0; Last = 1'b0; Out_Ready = 1'b1;
        repeat (2) @(negedge CLK);
        #1;
        total++;
        if (Out_Valid !== 1'b0) begin
            bad++; $display("FAIL reset_ov got=%b want=0", Out_Valid);
        end
        total++;
        if (R !== 16'h0000) begin
            bad++; $display("FAIL reset_r got=%h want=0000", R);
        end
        total++;
        if (In_Ready !== 1'b0) begin
            bad++; $display("FAIL reset_ir got=%b want=0", In_Ready);
        end
        @(negedge CLK);
        Reset_n = 1'b1;
    endtask

    task automatic test_zero();
        drive(1, 4'hA, 2'b00, 0, 1);
        drive(0, 4'h0, 2'b00, 0, 1);
        #1;
        total++;
        if (Out_Valid !== 1'b1 || R !== 16'h000A) begin
            bad++; $display("FAIL zero got ov=%b r=%h want ov=1 r=000a", Out_Valid, R);
        end
        @(negedge CLK); #1;
        total++;
        if (Out_Valid !== 1'b0) begin
            bad++; $display("FAIL zero_drain got ov=%b want 0", Out_Valid);
        end
    endtask

    task automatic test_sign_back_to_back();
        drive(1, 4'hA, 2'b01, 0, 1);
        drive(1, 4'h5, 2'b01, 0, 1);
        #1;
        total++;
        if (Out_Valid !== 1'b1 || R !== 16'hFFFA || In_Ready !== 1'b1) begin
            bad++;
            $display("FAIL sign_a got ov=%b r=%h ir=%b want 1 fffa 1", Out_Valid, R, In_Ready);
        end
        drive(0, 4'h0, 2'b00, 0, 1);
        #1;
        total++;
        if (Out_Valid !== 1'b1 || R !== 16'h0005) begin
            bad++; $display("FAIL sign_b got ov=%b r=%h want 1 0005", Out_Valid, R);
        end
        @(negedge CLK);
    endtask

    task automatic test_shift();
        drive(1, 4'h3, 2'b10, 0, 1);
        drive(0, 4'h0, 2'b00, 0, 1);
        #1;
        total++;
        if (Out_Valid !== 1'b1 || R !== 16'h0030) begin
            bad++; $display("FAIL shift got ov=%b r=%h want 1 0030", Out_Valid, R);
        end
        @(negedge CLK);
    endtask

    task automatic test_concat();
        logic [3:0] beats [4];
        beats = '{4'h1, 4'h2, 4'h3, 4'h4};
        for (int i = 0; i < 4; i++) begin
            drive(1, beats[i], (i == 0) ? 2'b11 : 2'($urandom_range(0, 3)), 0, 1);
            if (i > 0) begin
                #1;
                total++;
                if (Out_Valid !== 1'b0) begin
                    bad++; $display("FAIL concat_busy beat=%0d got ov=%b want 0", i, Out_Valid);
                end
            end
        end
        drive(0, 4'h0, 2'b00, 0, 1);
        #1;
        total++;
        if (Out_Valid !== 1'b1 || R !== 16'h1234) begin
            bad++; $display("FAIL concat_auto got ov=%b r=%h want 1 1234", Out_Valid, R);
        end
        drive(1, 4'h7, 2'b11, 0, 1);
        drive(1, 4'hB, 2'b00, 1, 1);
        drive(0, 4'h0, 2'b00, 0, 1);
        #1;
        total++;
        if (Out_Valid !== 1'b1 || R !== 16'h007B) begin
            bad++; $display("FAIL concat_last got ov=%b r=%h want 1 007b", Out_Valid, R);
        end
        @(negedge CLK);
    endtask

    task automatic test_backpressure();
        drive(1, 4'hF, 2'b00, 0, 0);
        drive(0, 4'h0, 2'b00, 0, 0);
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (Out_Valid !== 1'b1 || R !== 16'h000F || In_Ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d got ov=%b r=%h ir=%b want 1 000f 0",
                         i, Out_Valid, R, In_Ready);
            end
            @(negedge CLK);
        end
        In_Valid = 1'b1; A = 4'h8; Mode = 2'b01; Out_Ready = 1'b1;
        #1;
        total++;
        if (In_Ready !== 1'b1) begin
            bad++; $display("FAIL bp_release_ir got=%b want 1", In_Ready);
        end
        drive(0, 4'h0, 2'b00, 0, 1);
        #1;
        total++;
        if (Out_Valid !== 1'b1 || R !== 16'hFFF8) begin
            bad++; $display("FAIL bp_refill got ov=%b r=%h want 1 fff8", Out_Valid, R);
        end
        @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        drive(1, 4'h9, 2'b11, 0, 1);
        drive(1, 4'hC, 2'b11, 0, 1);
        drive(0, 4'h0, 2'b00, 0, 1);
        #2;
        Reset_n = 1'b0;
        #1;
        total++;
        if (Out_Valid !== 1'b0 || R !== 16'h0000 || In_Ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid got ov=%b r=%h ir=%b want 0 0000 0", Out_Valid, R, In_Ready);
        end
        @(negedge CLK);
        Reset_n = 1'b1;
        drive(1, 4'h1, 2'b11, 1, 1);
        drive(0, 4'h0, 2'b00, 0, 1);
        #1;
        total++;
        if (Out_Valid !== 1'b1 || R !== 16'h0001) begin
            bad++; $display("FAIL rst_after got ov=%b r=%h want 1 0001", Out_Valid, R);
        end
        @(negedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_random();
        int exp_q[$];
        bit in_cat = 0;
        int cval = 0;
        int ccnt = 0;
        bit exp_ir;
        int e;
        for (int cyc = 0; cyc < 600; cyc++) begin
            drive(1'($urandom_range(0, 99) < 60), 4'($urandom),
                  2'($urandom), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 99) < 70));
            #1;
            exp_ir = (exp_q.size() == 0) || Out_Ready;
            total++;
            if (Out_Valid !== (exp_q.size() != 0)) begin
                bad++;
                $display("FAIL rnd_ov cyc=%0d got=%b want=%b", cyc, Out_Valid, exp_q.size() != 0);
            end
            total++;
            if (In_Ready !== exp_ir) begin
                bad++; $display("FAIL rnd_ir cyc=%0d got=%b want=%b", cyc, In_Ready, exp_ir);
            end
            if (exp_q.size() != 0 && Out_Ready) begin
                e = exp_q.pop_front();
                total++;
                if (R !== 16'(e)) begin
                    bad++; $display("FAIL rnd_r cyc=%0d got=%h want=%h", cyc, R, 16'(e));
                end
            end
            if (In_Valid && exp_ir) begin
                if (in_cat) begin
                    cval = cval * 16 + int'(A);
                    ccnt++;
                    if (Last || ccnt == 4) begin
                        exp_q.push_back(cval);
                        in_cat = 0;
                    end
                end else begin
                    case (Mode)
                        2'b00: exp_q.push_back(int'(A));
                        2'b01: exp_q.push_back((A >= 8) ? int'(A) + 65520 : int'(A));
                        2'b10: exp_q.push_back(int'(A) * 16);
                        default: begin
                            cval = int'(A);
                            ccnt = 1;
                            if (Last) exp_q.push_back(cval);
                            else in_cat = 1;
                        end
                    endcase
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_sign_back_to_back();
        test_shift();
        test_concat();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
